// File: rtl/m_fft_out_serializer.sv
// Parallel-in, serial-out unload buffer for the 32-point FFT result frame.
// Define M_FFT_OUT_BITREV_EN to stream words in bit-reversed bin order.
module m_fft_out_serializer #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_din00, i_din01, i_din02, i_din03,
    input  logic [DATA_WIDTH-1:0] i_din04, i_din05, i_din06, i_din07,
    input  logic [DATA_WIDTH-1:0] i_din08, i_din09, i_din10, i_din11,
    input  logic [DATA_WIDTH-1:0] i_din12, i_din13, i_din14, i_din15,
    input  logic [DATA_WIDTH-1:0] i_din16, i_din17, i_din18, i_din19,
    input  logic [DATA_WIDTH-1:0] i_din20, i_din21, i_din22, i_din23,
    input  logic [DATA_WIDTH-1:0] i_din24, i_din25, i_din26, i_din27,
    input  logic [DATA_WIDTH-1:0] i_din28, i_din29, i_din30, i_din31,
    output logic                  o_load_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic [ADDR_WIDTH-1:0] o_out_addr,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic                  o_out_last,
    output logic                  o_done
);

    // state   | meaning
    // S_IDLE  | frame buffer free, waiting for a load strobe
    // S_STREAM| presenting frame words, one per accepted transfer
    typedef enum logic {S_IDLE, S_STREAM} t_state;

    t_state                r_state;
    t_state                w_next_state;
    logic [DATA_WIDTH-1:0] w_din   [DEPTH];
    logic [DATA_WIDTH-1:0] r_frame [DEPTH];
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0] w_index;
    logic                  r_done;
    logic                  w_load_ready;
    logic                  w_out_valid;
    logic                  w_capture;
    logic                  w_xfer;
    logic                  w_end;

    assign w_din[0]  = i_din00;  assign w_din[1]  = i_din01;
    assign w_din[2]  = i_din02;  assign w_din[3]  = i_din03;
    assign w_din[4]  = i_din04;  assign w_din[5]  = i_din05;
    assign w_din[6]  = i_din06;  assign w_din[7]  = i_din07;
    assign w_din[8]  = i_din08;  assign w_din[9]  = i_din09;
    assign w_din[10] = i_din10;  assign w_din[11] = i_din11;
    assign w_din[12] = i_din12;  assign w_din[13] = i_din13;
    assign w_din[14] = i_din14;  assign w_din[15] = i_din15;
    assign w_din[16] = i_din16;  assign w_din[17] = i_din17;
    assign w_din[18] = i_din18;  assign w_din[19] = i_din19;
    assign w_din[20] = i_din20;  assign w_din[21] = i_din21;
    assign w_din[22] = i_din22;  assign w_din[23] = i_din23;
    assign w_din[24] = i_din24;  assign w_din[25] = i_din25;
    assign w_din[26] = i_din26;  assign w_din[27] = i_din27;
    assign w_din[28] = i_din28;  assign w_din[29] = i_din29;
    assign w_din[30] = i_din30;  assign w_din[31] = i_din31;

    assign w_capture = (r_state == S_IDLE) && i_load;
    assign w_xfer    = (r_state == S_STREAM) && i_out_ready;
    assign w_end     = w_xfer && (r_count == ADDR_WIDTH'(DEPTH - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (i_load) w_next_state = S_STREAM;
            S_STREAM: if (w_end)  w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_load_ready = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE:   w_load_ready = 1'b1;
            S_STREAM: w_out_valid  = 1'b1;
            default:  w_load_ready = 1'b1;
        endcase
    end

    // Counter wraps naturally to 0 on the final transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_done  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_frame[i] <= '0;
        end else begin
            r_done <= w_end;
            if (w_capture) begin
                r_count <= '0;
                for (int i = 0; i < DEPTH; i++) r_frame[i] <= w_din[i];
            end else if (w_xfer) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

`ifdef M_FFT_OUT_BITREV_EN
    always_comb begin
        w_index = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) w_index[i] = r_count[ADDR_WIDTH-1-i];
    end
`else
    assign w_index = r_count;
`endif

    assign o_load_ready = w_load_ready;
    assign o_out_valid  = w_out_valid;
    assign o_out_addr   = w_index;
    assign o_out_data   = r_frame[w_index];
    assign o_out_last   = w_out_valid && (r_count == ADDR_WIDTH'(DEPTH - 1));
    assign o_done       = r_done;

endmodule

// File: tb/tb_m_fft_out_serializer.sv
// Directed/randomized bench for m_fft_out_serializer against a frame-level
// reference: each frame is the captured word array read out in index order.
module tb_m_fft_out_serializer;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_load = 1'b0;
    logic        i_out_ready = 1'b0;
    logic [15:0] din_drv [32];
    logic        o_load_ready;
    logic [15:0] o_out_data;
    logic [4:0]  o_out_addr;
    logic        o_out_valid;
    logic        o_out_last;
    logic        o_done;

    logic [15:0] model_frame [32];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 i_clk = ~i_clk;

    m_fft_out_serializer dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(i_load),
        .i_din00(din_drv[0]),  .i_din01(din_drv[1]),  .i_din02(din_drv[2]),  .i_din03(din_drv[3]),
        .i_din04(din_drv[4]),  .i_din05(din_drv[5]),  .i_din06(din_drv[6]),  .i_din07(din_drv[7]),
        .i_din08(din_drv[8]),  .i_din09(din_drv[9]),  .i_din10(din_drv[10]), .i_din11(din_drv[11]),
        .i_din12(din_drv[12]), .i_din13(din_drv[13]), .i_din14(din_drv[14]), .i_din15(din_drv[15]),
        .i_din16(din_drv[16]), .i_din17(din_drv[17]), .i_din18(din_drv[18]), .i_din19(din_drv[19]),
        .i_din20(din_drv[20]), .i_din21(din_drv[21]), .i_din22(din_drv[22]), .i_din23(din_drv[23]),
        .i_din24(din_drv[24]), .i_din25(din_drv[25]), .i_din26(din_drv[26]), .i_din27(din_drv[27]),
        .i_din28(din_drv[28]), .i_din29(din_drv[29]), .i_din30(din_drv[30]), .i_din31(din_drv[31]),
        .o_load_ready(o_load_ready), .o_out_data(o_out_data), .o_out_addr(o_out_addr),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_last(o_out_last),
        .o_done(o_done)
    );

    function automatic int idx(input int k);
        int r;
        r = k;
`ifdef M_FFT_OUT_BITREV_EN
        r = 0;
        for (int b = 0; b < 5; b++) r = r + (((k >> b) & 1) << (4 - b));
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_load_ready"}, 32'(o_load_ready), 32'd1);
        chk({tag, "_valid"}, 32'(o_out_valid), 32'd0);
        chk({tag, "_last"}, 32'(o_out_last), 32'd0);
    endtask

    // Called just after a negedge while idle; returns one negedge later.
    task automatic start_load(input int kind);
        chk("pre_load_ready", 32'(o_load_ready), 32'd1);
        for (int i = 0; i < 32; i++)
            din_drv[i] = (kind == 0) ? 16'(16'h0100 + i) : 16'($urandom);
        for (int i = 0; i < 32; i++) model_frame[i] = din_drv[i];
        i_load = 1'b1;
        @(negedge i_clk);
        i_load = 1'b0;
    endtask

    // mode 0: ready always high, 1: fixed 1,0,0,1,0,1 pattern, 2: random.
    task automatic run_stream(input int mode, input int inject_at, input int abort_at);
        int   k;
        int   cyc;
        bit   injected;
        logic r;
        logic pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        k = 0;
        cyc = 0;
        injected = 1'b0;
        while (k < 32) begin
            if (k == abort_at) begin
                i_rst_n = 1'b0;
                #1;
                chk_idle("async_rst");
                chk("async_rst_data", 32'(o_out_data), 32'd0);
                chk("async_rst_addr", 32'(o_out_addr), 32'd0);
                chk("async_rst_done", 32'(o_done), 32'd0);
                return;
            end
            chk("valid", 32'(o_out_valid), 32'd1);
            chk("busy_load_ready", 32'(o_load_ready), 32'd0);
            chk("addr", 32'(o_out_addr), 32'(idx(k)));
            chk("data", 32'(o_out_data), 32'(model_frame[idx(k)]));
            chk("last", 32'(o_out_last), 32'(k == 31));
            chk("done_mid", 32'(o_done), 32'd0);
            if (k == inject_at && !injected) begin
                for (int i = 0; i < 32; i++) din_drv[i] = ~model_frame[i];
                i_load = 1'b1;
                injected = 1'b1;
            end else begin
                i_load = 1'b0;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = pat[cyc % 6];
                default: r = 1'($urandom_range(0, 1));
            endcase
            i_out_ready = r;
            @(negedge i_clk);
            cyc++;
            if (r) k++;
            if (cyc > 2000) begin
                n_cmp++;
                n_err++;
                $error("FAIL stream_timeout: observed %0d words expected 32", k);
                return;
            end
        end
        i_load = 1'b0;
        chk("done_pulse", 32'(o_done), 32'd1);
        chk_idle("done_cycle");
        chk("done_cycle_addr", 32'(o_out_addr), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) din_drv[i] = 16'h0;
        #1;
        chk_idle("reset");
        chk("reset_data", 32'(o_out_data), 32'd0);
        chk("reset_addr", 32'(o_out_addr), 32'd0);
        chk("reset_done", 32'(o_done), 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk_idle("post_reset");

        // Ramp frame at full throughput.
        start_load(0);
        run_stream(0, -1, -1);
        @(negedge i_clk);
        chk("done_clear", 32'(o_done), 32'd0);
        chk_idle("after_ramp");

        // Fixed backpressure pattern.
        start_load(1);
        run_stream(1, -1, -1);
        @(negedge i_clk);
        chk("done_clear_bp", 32'(o_done), 32'd0);

        // Random backpressure plus an ignored load at word 5, then back-to-back.
        start_load(1);
        run_stream(2, 5, -1);
        start_load(1);
        run_stream(0, -1, -1);
        @(negedge i_clk);
        chk("done_clear_b2b", 32'(o_done), 32'd0);

        // Reset mid-frame at word 10; nothing stale may follow.
        start_load(0);
        run_stream(0, -1, 10);
        @(negedge i_clk);
        chk_idle("rst_held");
        i_rst_n = 1'b1;
        i_out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            chk_idle("post_abort");
            chk("post_abort_data", 32'(o_out_data), 32'd0);
            chk("post_abort_done", 32'(o_done), 32'd0);
        end

        // Recovery frame with random backpressure.
        start_load(1);
        run_stream(2, -1, -1);
        @(negedge i_clk);
        chk_idle("final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/m_fft_out_serializer.md
# m_fft_out_serializer

Parallel-in, serial-out unload buffer for the 32-point FFT datapath. It captures a full 32-word frame in one cycle from the parallel result bus and streams it out one word per cycle over a valid/ready handshake, tagging each word with its bin address. It is the read-side counterpart of the serial-write, parallel-read register file that feeds the butterfly stages, and it sits between the final FFT stage and the UART/host output path.

## Interface
- ADDR_WIDTH, 5, width of the bin address and word counter
- DATA_WIDTH, 16, width of each data word
- DEPTH, 32, words per frame; must equal 2**ADDR_WIDTH

- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- load  input  1  frame-capture strobe; sampled only while load_ready=1
- din00 … din31  input  DATA_WIDTH each  parallel frame words, bin k on dinKK
- load_ready  output  1  high when idle and able to capture a frame
- out_data  output  DATA_WIDTH  current streamed word
- out_addr  output  ADDR_WIDTH  bin index of out_data
- out_valid  output  1  out_data/out_addr/out_last are valid
- out_ready  input  1  downstream accepts the word this cycle
- out_last  output  1  high with the final word of the frame
- done  output  1  one-cycle pulse after the final word is accepted

## Operation
- Storage: DEPTH x DATA_WIDTH frame registers, written only on capture.
- State machine, two states:
  - IDLE: load_ready=1, out_valid=0. On load=1: all 32 din words written to the frame registers, counter cleared to 0, next state STREAM.
  - STREAM: load_ready=0, out_valid=1. Transfer occurs when out_valid && out_ready. Each transfer increments the counter. A transfer with counter = DEPTH-1 ends the frame: next state IDLE, done=1 for the following cycle.
- Read mux: out_addr = index(counter); out_data = frame[out_addr]; out_last = (counter == DEPTH-1).
- Stall: while out_valid=1 and out_ready=0, out_data, out_addr and out_last are held unchanged. out_valid never drops mid-frame.
- load while in STREAM is ignored; the frame registers are not modified.
- Counter is ADDR_WIDTH bits and wraps to 0 at frame end.
- Reset (asynchronous, at any time, including mid-frame): state IDLE, counter 0, frame registers 0, load_ready=1, out_valid=0, out_last=0, out_data=0, out_addr=0, done=0. Any partially streamed frame is discarded.

## Timing
- Capture: load=1 sampled at edge E → out_valid=1 and word 0 presented in the cycle after E.
- Throughput: 1 word/cycle with out_ready held high; a frame of 32 words occupies 32 consecutive cycles after capture.
- done: asserted in the cycle immediately after the last transfer. load_ready=1 in that same cycle, so a new load can be captured there. Back-to-back frames therefore incur a 1-cycle bubble.
- out_ready toggling has no effect on ordering: each word is transferred exactly once, in order.
- Outputs are driven from registers and the registered counter only. There is no combinational path from out_ready or load to out_data.

## Configuration
- Macro: M_FFT_OUT_BITREV_EN.
- Defined: index(counter) is the ADDR_WIDTH-bit bit-reversal of counter. Words leave in bit-reversed bin order, which undoes DIT output ordering. out_addr carries the reversed index.
- Undefined: index(counter) = counter, giving natural order. out_addr equals the transfer number.
- out_last and done always key off the counter, never off out_addr.

## Test plan
- Reset/idle: assert rst_n=0 mid-STREAM at word 10 → next cycle out_valid=0, load_ready=1, out_data=0. After release, no stale words are emitted.
- Natural-order stream (macro undefined): dinKK=16'h0100+K, load pulse, out_ready=1 → 32 words 16'h0100..16'h011F with out_addr 0..31. out_last is set only on word 31. done pulses one cycle later.
- Bit-reversed stream (macro defined): same frame → out_addr sequence 0,16,8,24,4,… and out_data=16'h0100+out_addr on each word. Last word has out_addr=31.
- Backpressure: out_ready pattern 1,0,0,1,0,1… → every word held stable while stalled. Exactly 32 transfers occur, with no duplicates and no drops.
- Load during STREAM: second load with different din at word 5 → the remaining words still come from the first frame, and load_ready stays 0.
- Back-to-back: load asserted in the done cycle with a new frame → the second frame's word 0 appears on the next cycle, with a 1-cycle gap between frames.
